// File: rtl/shift_seq_pkg.sv
// ============================================================================
// Module   : shift_seq_pkg
// Purpose  : Shared encodings and defaults for the shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SAW_DEF   = 5;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_seq_if.sv
// ============================================================================
// Module   : shift_seq_if
// Purpose  : Request/response bundle between control unit and shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_seq_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SAW   = SAW_DEF
);

  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] data;
  logic [SAW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, op, data, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, data, shamt,
    output busy, done, result
  );

endinterface

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single step of the sequencer: shift by 1 or by 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  wire logic [WIDTH-1:0] value,
  input  wire logic [1:0]       op,
  input  wire logic             by4,
  output logic      [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    if (by4) begin
      case (op)
        OP_SLL:  result = {value[WIDTH-5:0], 4'b0000};
        OP_SRL:  result = {4'b0000, value[WIDTH-1:4]};
        OP_SRA:  result = {{4{value[WIDTH-1]}}, value[WIDTH-1:4]};
        default: result = {value[3:0], value[WIDTH-1:4]};
      endcase
    end else begin
      case (op)
        OP_SLL:  result = {value[WIDTH-2:0], 1'b0};
        OP_SRL:  result = {1'b0, value[WIDTH-1:1]};
        OP_SRA:  result = {value[WIDTH-1], value[WIDTH-1:1]};
        default: result = {value[0], value[WIDTH-1:1]};
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_seq.sv
// ============================================================================
// Module   : shift_seq
// Purpose  : Iterative shift sequencer (SLL/SRL/SRA/ROTR), one step per cycle.
//            Define SHIFT_SEQ_BY4_EN to take 4-bit steps while count >= 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SAW   = SAW_DEF
) (
  input  wire logic    clk,
  input  wire logic    rst,
  shift_seq_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [SAW-1:0]   count_q, count_d;

  logic [WIDTH-1:0] step_out;
  logic             by4;
  logic [SAW-1:0]   step_dec;

`ifdef SHIFT_SEQ_BY4_EN
  assign by4 = (count_q >= SAW'(4));
`else
  assign by4 = 1'b0;
`endif

  assign step_dec = by4 ? SAW'(4) : SAW'(1);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value  (result_q),
    .op     (op_q),
    .by4    (by4),
    .result (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      op_q     <= OP_SLL;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
      count_q  <= count_d;
    end
  end

  // DONE accepts a new start exactly like IDLE so back-to-back ops need no bubble.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    op_d     = op_q;
    count_d  = count_q;
    case (state_q)
      ST_SHIFT: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          result_d = step_out;
          count_d  = count_q - step_dec;
          if (count_d == '0) state_d = ST_DONE;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (bus.start) begin
          result_d = bus.data;
          op_d     = bus.op;
          count_d  = bus.shamt;
          state_d  = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign bus.busy   = (state_q == ST_SHIFT);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq.sv
// ============================================================================
// Module   : tb_shift_seq
// Purpose  : Scoreboard bench for shift_seq with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq;
  import shift_seq_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          busy_n;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  int   busy_run;
  exp_t sb[$];

  shift_seq_if #(.WIDTH(32), .SAW(5)) bus ();

  shift_seq #(.WIDTH(32), .SAW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input logic [4:0] s);
`ifdef SHIFT_SEQ_BY4_EN
    return int'(s / 5'd4) + int'(s % 5'd4) + 1;
`else
    return int'(s) + 1;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        checks++;
        if (bus.busy) begin
          failures++;
          $display("FAIL busy_with_done busy=%0b required=0", bus.busy);
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done result=%h cyc=%0d required=no done", bus.result, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.result !== e.res) begin
            failures++;
            $display("FAIL result got=%h required=%h", bus.result, e.res);
          end
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL latency done_cyc=%0d required=%0d", cyc, e.cyc);
          end
          checks++;
          if (busy_run != e.busy_n) begin
            failures++;
            $display("FAIL busy_cycles got=%0d required=%0d", busy_run, e.busy_n);
          end
        end
        busy_run = 0;
      end else if (bus.busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                       input logic [31:0] r, input bit track);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = o;
    bus.data  = d;
    bus.shamt = s;
    if (track) begin
      e.res    = r;
      e.cyc    = cyc + lat(s);
      e.busy_n = lat(s) - 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout got=no done required=done within 200 cycles");
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL %s busy=%0b done=%0b required busy=0 done=0", name, bus.busy, bus.done);
    end
  endtask

  logic [1:0]  v_op  [14];
  logic [31:0] v_dat [14];
  logic [4:0]  v_sh  [14];
  logic [31:0] v_exp [14];

  initial begin
    v_op  = '{OP_SLL, OP_SRA, OP_SRL, OP_ROTR, OP_SLL, OP_SRA, OP_ROTR,
              OP_SRA, OP_ROTR, OP_SRL, OP_SLL, OP_SRA, OP_ROTR, OP_SRA};
    v_dat = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h00000001,
              32'h12345678, 32'h12345678, 32'h12345678, 32'h80000000,
              32'h12345678, 32'hF0000000, 32'h12345678, 32'h7FFFFFFF,
              32'h0000000F, 32'h80000001};
    v_sh  = '{5'd31, 5'd4, 5'd4, 5'd1, 5'd0, 5'd0, 5'd0,
              5'd31, 5'd8, 5'd5, 5'd4, 5'd3, 5'd6, 5'd7};
    v_exp = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'h80000000,
              32'h12345678, 32'h12345678, 32'h12345678, 32'hFFFFFFFF,
              32'h78123456, 32'h07800000, 32'h23456780, 32'h0FFFFFFF,
              32'h3C000000, 32'hFF000000};

    checks = 0; failures = 0; busy_run = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = OP_SLL; bus.data = '0; bus.shamt = '0;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    checks++;
    if (bus.result !== 32'h0) begin
      failures++;
      $display("FAIL reset_result got=%h required=00000000", bus.result);
    end
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-shift: outputs clear without waiting for a clock edge.
    issue(OP_SLL, 32'h1, 5'd31, 32'h0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle("async_reset");
    checks++;
    if (bus.result !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_result got=%h required=00000000", bus.result);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      issue(v_op[i], v_dat[i], v_sh[i], v_exp[i], 1'b1);
      wait_done();
      @(negedge clk);
    end

    // Back-to-back: new start issued while done is high.
    issue(OP_SRL, 32'h80000000, 5'd3, 32'h10000000, 1'b1);
    wait_done();
    issue(OP_SLL, 32'h00000003, 5'd2, 32'h0000000C, 1'b1);
    wait_done();
    @(negedge clk);

    // Start during SHIFT is ignored.
    issue(OP_SLL, 32'h1, 5'd8, 32'h00000100, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    issue(OP_SRL, 32'hFFFF0000, 5'd0, 32'h0, 1'b0);
    wait_done();
    @(negedge clk);

    // Flush at SHIFT cycle 2: back to idle, no done afterward.
    issue(OP_SLL, 32'h1, 5'd10, 32'h0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_idle("flush_shift");
    repeat (15) @(negedge clk);

    // Flush and start together: start dropped.
    issue(OP_SLL, 32'h5, 5'd0, 32'h0, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check_idle("flush_with_start");
    repeat (5) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_done outstanding=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required=finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
